// File: rtl/mac_feeder.sv
// Operand feeder for a registered multiply-accumulate unit: runs k_len handshakes per job,
// flags the first product of a job as a restart and pulses result_valid once the MAC has the sum.
module mac_feeder #(
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      arst_in,
  input  logic                      start,
  input  logic [COUNT_WIDTH-1:0]    k_len,
  input  logic                      abort,
  output logic                      busy,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [A_WIDTH-1:0]        op_a,
  input  logic signed [B_WIDTH-1:0] op_b,
  output logic                      mac_input_valid,
  output logic                      mac_accumulate_internal,
  output logic [A_WIDTH-1:0]        mac_a,
  output logic signed [B_WIDTH-1:0] mac_b,
  output logic                      result_valid
);

  // state | meaning
  // IDLE  | waiting for start with a non-zero k_len
  // FEED  | accepting operand pairs until remaining reaches zero
  // DRAIN | last product is in the MAC register stage; result follows next cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   first;
  logic                   job_accept;
  logic                   handshake;

  assign job_accept = (state == IDLE) && start && (k_len != '0);
  assign op_ready   = (state == FEED) && !abort;
  assign handshake  = op_valid && op_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_accept) state_nxt = FEED;
      FEED: begin
        if (abort)
          state_nxt = IDLE;
        else if (handshake && remaining == COUNT_WIDTH'(1))
          state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      remaining <= '0;
      first     <= 1'b0;
    end else if (job_accept) begin
      remaining <= k_len;
      first     <= 1'b1;
    end else if (handshake) begin
      remaining <= remaining - COUNT_WIDTH'(1);
      first     <= 1'b0;
    end
  end

  // Operands are held between handshakes so the MAC inputs stay quiet during bubbles.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      mac_input_valid         <= 1'b0;
      mac_accumulate_internal <= 1'b0;
      mac_a                   <= '0;
      mac_b                   <= '0;
      result_valid            <= 1'b0;
    end else begin
      mac_input_valid         <= handshake;
      mac_accumulate_internal <= handshake && !first;
      if (handshake) begin
        mac_a <= op_a;
        mac_b <= op_b;
      end
      result_valid <= (state == DRAIN) && !abort;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a small registered MAC model driven by the feeder outputs.
module tb_mac_feeder;

  logic              clk = 1'b0;
  logic              arst_in;
  logic              start;
  logic [15:0]       k_len;
  logic              abort;
  logic              busy;
  logic              op_valid;
  logic              op_ready;
  logic [7:0]        op_a;
  logic signed [7:0] op_b;
  logic              mac_input_valid;
  logic              mac_accumulate_internal;
  logic [7:0]        mac_a;
  logic signed [7:0] mac_b;
  logic              result_valid;

  int checks   = 0;
  int failures = 0;
  int mac_out;

  mac_feeder dut (
    .clk                     (clk),
    .arst_in                 (arst_in),
    .start                   (start),
    .k_len                   (k_len),
    .abort                   (abort),
    .busy                    (busy),
    .op_valid                (op_valid),
    .op_ready                (op_ready),
    .op_a                    (op_a),
    .op_b                    (op_b),
    .mac_input_valid         (mac_input_valid),
    .mac_accumulate_internal (mac_accumulate_internal),
    .mac_a                   (mac_a),
    .mac_b                   (mac_b),
    .result_valid            (result_valid)
  );

  always #5 clk = ~clk;

  // Downstream MAC: registers a*b on input_valid, restarting or accumulating.
  always @(posedge clk or posedge arst_in) begin
    if (arst_in) mac_out <= 0;
    else if (mac_input_valid)
      mac_out <= (mac_accumulate_internal ? mac_out : 0) + int'(mac_a) * int'(mac_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_in = 1'b1; start = 0; k_len = 0; abort = 0; op_valid = 0; op_a = 0; op_b = 0;
    step(); step();
    checks++;
    if ({busy, op_ready, mac_input_valid, mac_accumulate_internal, result_valid} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=00000",
        {busy, op_ready, mac_input_valid, mac_accumulate_internal, result_valid});
    end
    checks++;
    if ({mac_a, mac_b} !== 16'h0) begin
      failures++; $display("FAIL reset_operands got=%h want=0000", {mac_a, mac_b});
    end
    arst_in = 1'b0;
    step();
  endtask

  // k_len=3 with (1,4),(2,5),(3,-6), then a start on the result_valid cycle.
  task automatic test_basic();
    start = 1; k_len = 3; op_valid = 1; op_a = 1; op_b = 4;
    step();                                            // cycle 1
    start = 0;
    checks++;
    if (op_ready !== 1'b1 || busy !== 1'b1 || mac_input_valid !== 1'b0) begin
      failures++; $display("FAIL basic_c1 rdy=%b busy=%b iv=%b want 1 1 0", op_ready, busy, mac_input_valid);
    end
    step(); op_a = 2; op_b = 5;                        // cycle 2
    checks++;
    if (mac_input_valid !== 1 || mac_accumulate_internal !== 0 || mac_a !== 8'd1 || mac_b !== 8'sd4) begin
      failures++; $display("FAIL basic_c2 iv=%b acc=%b a=%0d b=%0d want 1 0 1 4",
        mac_input_valid, mac_accumulate_internal, mac_a, mac_b);
    end
    step(); op_a = 3; op_b = -6;                       // cycle 3
    checks++;
    if (mac_input_valid !== 1 || mac_accumulate_internal !== 1 || mac_a !== 8'd2 || op_ready !== 1) begin
      failures++; $display("FAIL basic_c3 iv=%b acc=%b a=%0d rdy=%b want 1 1 2 1",
        mac_input_valid, mac_accumulate_internal, mac_a, op_ready);
    end
    step();                                            // cycle 4, DRAIN
    checks++;
    if (mac_input_valid !== 1 || mac_accumulate_internal !== 1 || mac_b !== -8'sd6 ||
        op_ready !== 0 || result_valid !== 0 || busy !== 1) begin
      failures++; $display("FAIL basic_c4 iv=%b acc=%b b=%0d rdy=%b rv=%b busy=%b want 1 1 -6 0 0 1",
        mac_input_valid, mac_accumulate_internal, mac_b, op_ready, result_valid, busy);
    end
    step();                                            // cycle 5
    checks++;
    if (result_valid !== 1 || busy !== 0 || mac_out !== -4 || mac_input_valid !== 0) begin
      failures++; $display("FAIL basic_c5 rv=%b busy=%b out=%0d iv=%b want 1 0 -4 0",
        result_valid, busy, mac_out, mac_input_valid);
    end
    start = 1; k_len = 1; op_a = 3; op_b = 3;
    step();                                            // cycle 6
    start = 0;
    checks++;
    if (busy !== 1 || op_ready !== 1 || result_valid !== 0) begin
      failures++; $display("FAIL b2b_start busy=%b rdy=%b rv=%b want 1 1 0", busy, op_ready, result_valid);
    end
    step(); op_valid = 0;                              // cycle 7
    checks++;
    if (mac_input_valid !== 1 || mac_accumulate_internal !== 0) begin
      failures++; $display("FAIL b2b_first iv=%b acc=%b want 1 0", mac_input_valid, mac_accumulate_internal);
    end
    step();                                            // cycle 8
    checks++;
    if (result_valid !== 1 || mac_out !== 9) begin
      failures++; $display("FAIL b2b_result rv=%b out=%0d want 1 9", result_valid, mac_out);
    end
    step();
  endtask

  // k_len=4, op_valid 1,0,1,1,0,1, operands a=b=cycle number.
  task automatic test_bubbles();
    logic [1:8] pat     = 8'b10110100;
    logic [1:8] exp_rdy = 8'b11111100;
    logic [1:8] exp_iv  = 8'b01011010;
    logic [1:8] exp_acc = 8'b00011010;
    logic [1:8] exp_rv  = 8'b00000001;
    start = 1; k_len = 4; op_valid = 0;
    step();
    start = 0;
    for (int c = 1; c <= 8; c++) begin
      op_valid = pat[c]; op_a = 8'(c); op_b = 8'(c);
      #1;
      checks++;
      if (op_ready !== exp_rdy[c] || mac_input_valid !== exp_iv[c] ||
          mac_accumulate_internal !== exp_acc[c] || result_valid !== exp_rv[c]) begin
        failures++; $display("FAIL bubbles_c%0d rdy=%b iv=%b acc=%b rv=%b want %b %b %b %b", c,
          op_ready, mac_input_valid, mac_accumulate_internal, result_valid,
          exp_rdy[c], exp_iv[c], exp_acc[c], exp_rv[c]);
      end
      if (c < 8) step();
    end
    checks++;
    if (mac_out !== 62) begin
      failures++; $display("FAIL bubbles_sum got=%0d want=62", mac_out);
    end
    op_valid = 0;
    step();
  endtask

  task automatic test_single();
    start = 1; k_len = 1; op_valid = 1; op_a = 255; op_b = -128;
    step(); start = 0;                                 // handshake cycle
    step(); op_valid = 0;
    checks++;
    if (mac_input_valid !== 1 || mac_accumulate_internal !== 0 || mac_a !== 8'd255 ||
        mac_b !== -8'sd128 || result_valid !== 0) begin
      failures++; $display("FAIL single_mac iv=%b acc=%b a=%0d b=%0d rv=%b want 1 0 255 -128 0",
        mac_input_valid, mac_accumulate_internal, mac_a, mac_b, result_valid);
    end
    step();
    checks++;
    if (result_valid !== 1 || mac_out !== -32640 || mac_input_valid !== 0) begin
      failures++; $display("FAIL single_result rv=%b out=%0d iv=%b want 1 -32640 0",
        result_valid, mac_out, mac_input_valid);
    end
    step();
  endtask

  task automatic test_ignored_start();
    int rv_seen = 0;
    start = 1; k_len = 0; op_valid = 1;
    step(); step();
    checks++;
    if (busy !== 0 || result_valid !== 0 || op_ready !== 0) begin
      failures++; $display("FAIL kzero busy=%b rv=%b rdy=%b want 0 0 0", busy, result_valid, op_ready);
    end
    k_len = 2; op_valid = 0;
    step();                                            // FEED, start held with a new length
    k_len = 7;
    step();
    start = 0; op_valid = 1; op_a = 1; op_b = 1;
    checks++;
    if (busy !== 1 || op_ready !== 1) begin
      failures++; $display("FAIL busy_start busy=%b rdy=%b want 1 1", busy, op_ready);
    end
    step(); step();                                    // two handshakes
    op_valid = 0;
    checks++;
    if (op_ready !== 0 || busy !== 1) begin
      failures++; $display("FAIL busy_drain rdy=%b busy=%b want 0 1", op_ready, busy);
    end
    step();
    checks++;
    if (result_valid !== 1 || mac_out !== 2) begin
      failures++; $display("FAIL busy_result rv=%b out=%0d want 1 2", result_valid, mac_out);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (result_valid === 1'b1) rv_seen++;
    end
    checks++;
    if (rv_seen != 0 || busy !== 0) begin
      failures++; $display("FAIL busy_extra rv_count=%0d busy=%b want 0 0", rv_seen, busy);
    end
  endtask

  task automatic test_abort();
    start = 1; k_len = 5; op_valid = 1; op_a = 9; op_b = 9;
    step(); start = 0;
    step(); step();                                    // two handshakes done
    abort = 1;
    #1;
    checks++;
    if (op_ready !== 0) begin
      failures++; $display("FAIL abort_ready got=%b want=0", op_ready);
    end
    step();
    abort = 0;
    checks++;
    if (busy !== 0 || mac_input_valid !== 0 || result_valid !== 0) begin
      failures++; $display("FAIL abort_idle busy=%b iv=%b rv=%b want 0 0 0", busy, mac_input_valid, result_valid);
    end
    // New job, started with abort high in IDLE, which must not matter.
    start = 1; k_len = 2; abort = 1; op_a = 7; op_b = 3;
    step();
    start = 0; abort = 0;
    checks++;
    if (busy !== 1 || result_valid !== 0) begin
      failures++; $display("FAIL abort_restart busy=%b rv=%b want 1 0", busy, result_valid);
    end
    step(); op_a = 2; op_b = -1;
    checks++;
    if (mac_input_valid !== 1 || mac_accumulate_internal !== 0) begin
      failures++; $display("FAIL abort_newfirst iv=%b acc=%b want 1 0", mac_input_valid, mac_accumulate_internal);
    end
    step(); op_valid = 0;
    step();
    checks++;
    if (result_valid !== 1 || mac_out !== 19) begin
      failures++; $display("FAIL abort_newresult rv=%b out=%0d want 1 19", result_valid, mac_out);
    end
    // Abort during DRAIN suppresses the result.
    start = 1; k_len = 1; op_valid = 1;
    step(); start = 0;
    step(); op_valid = 0; abort = 1;
    step(); abort = 0;
    checks++;
    if (result_valid !== 0 || busy !== 0) begin
      failures++; $display("FAIL abort_drain rv=%b busy=%b want 0 0", result_valid, busy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    start = 1; k_len = 3; op_valid = 1; op_a = 5; op_b = 5;
    step(); start = 0;
    step(); #2;
    arst_in = 1;
    #1;
    checks++;
    if ({busy, op_ready, mac_input_valid, mac_accumulate_internal, result_valid} !== 5'b0 ||
        {mac_a, mac_b} !== 16'h0) begin
      failures++; $display("FAIL reset_mid flags=%b ops=%h want 00000 0000",
        {busy, op_ready, mac_input_valid, mac_accumulate_internal, result_valid}, {mac_a, mac_b});
    end
    op_valid = 0;
    step();
    arst_in = 0;
    step(); step();
    checks++;
    if (busy !== 0) begin
      failures++; $display("FAIL reset_wait busy=%b want 0", busy);
    end
    start = 1; k_len = 2; op_valid = 1; op_a = 1; op_b = 4;
    step(); start = 0;
    step(); op_a = 2; op_b = 5;
    checks++;
    if (mac_input_valid !== 1 || mac_accumulate_internal !== 0 || mac_a !== 8'd1) begin
      failures++; $display("FAIL reset_job1 iv=%b acc=%b a=%0d want 1 0 1",
        mac_input_valid, mac_accumulate_internal, mac_a);
    end
    step(); op_valid = 0;
    checks++;
    if (mac_input_valid !== 1 || mac_accumulate_internal !== 1 || op_ready !== 0) begin
      failures++; $display("FAIL reset_job2 iv=%b acc=%b rdy=%b want 1 1 0",
        mac_input_valid, mac_accumulate_internal, op_ready);
    end
    step();
    checks++;
    if (result_valid !== 1 || mac_out !== 14) begin
      failures++; $display("FAIL reset_job_result rv=%b out=%0d want 1 14", result_valid, mac_out);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_single();
    test_ignored_start();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
